// File: rtl/shift_sequencer.sv
// Multi-cycle signed shifter: splits a long shift into passes of at most STEP_MAX positions,
// accumulating right-shift sticky and left-shift overflow flags along the way.
module shift_sequencer #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned STEP_BITS = 2,
    parameter int unsigned AMT_BITS  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    input  logic [AMT_BITS-1:0] in_amt,
    input  logic                in_dir,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_sticky,
    output logic                out_ovf,
    output logic [AMT_BITS-1:0] out_passes
);

    localparam int unsigned STEP_MAX = (2 ** STEP_BITS) - 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      data_q, data_d;
    logic                  dir_q, dir_d;
    logic [AMT_BITS-1:0]   rem_q, rem_d;
    logic                  sticky_q, sticky_d;
    logic                  ovf_q, ovf_d;
    logic [AMT_BITS-1:0]   passes_q, passes_d;

    logic [STEP_BITS-1:0]  step;
    logic [WIDTH-1:0]      drop_mask;
    logic                  ovf_hit;

    always_comb begin
        if (rem_q > AMT_BITS'(STEP_MAX)) begin
            step = STEP_BITS'(STEP_MAX);
        end else begin
            step = rem_q[STEP_BITS-1:0];
        end
        drop_mask = ~({WIDTH{1'b1}} << step);
        // Left pass overflows if any of the top step bits below the MSB differ from it.
        ovf_hit = 1'b0;
        for (int unsigned i = 1; i <= STEP_MAX; i++) begin
            if (i <= 32'(step) && (data_q[WIDTH-1-i] != data_q[WIDTH-1])) begin
                ovf_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        dir_d    = dir_q;
        rem_d    = rem_q;
        sticky_d = sticky_q;
        ovf_d    = ovf_q;
        passes_d = passes_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    data_d   = in_data;
                    dir_d    = in_dir;
                    rem_d    = in_amt;
                    sticky_d = 1'b0;
                    ovf_d    = 1'b0;
                    passes_d = '0;
                    state_d  = (in_amt != '0) ? StShift : StDone;
                end
            end
            StShift: begin
                if (dir_q) begin
                    data_d   = WIDTH'($signed(data_q) >>> step);
                    sticky_d = sticky_q | (|(data_q & drop_mask));
                end else begin
                    data_d = data_q << step;
                    ovf_d  = ovf_q | ovf_hit;
                end
                rem_d    = rem_q - AMT_BITS'(step);
                passes_d = passes_q + AMT_BITS'(1);
                if (rem_d == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            data_q   <= '0;
            dir_q    <= 1'b0;
            rem_q    <= '0;
            sticky_q <= 1'b0;
            ovf_q    <= 1'b0;
            passes_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            dir_q    <= dir_d;
            rem_q    <= rem_d;
            sticky_q <= sticky_d;
            ovf_q    <= ovf_d;
            passes_q <= passes_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign out_data   = data_q;
    assign out_sticky = sticky_q;
    assign out_ovf    = ovf_q;
    assign out_passes = passes_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: hand-computed results, latency, backpressure and reset.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [4:0]  in_amt;
    logic        in_dir;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sticky;
    logic        out_ovf;
    logic [4:0]  out_passes;

    int total = 0;
    int bad   = 0;
    int cyc;
    logic [15:0] hold_data;

    shift_sequencer #(
        .WIDTH    (16),
        .STEP_BITS(2),
        .AMT_BITS (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sticky(out_sticky),
        .out_ovf   (out_ovf),
        .out_passes(out_passes)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE; c counts cycles after the accept edge until out_valid.
    task automatic run(input logic [15:0] d, input logic [4:0] a, input logic dir,
                       output int c);
        in_data  = d;
        in_amt   = a;
        in_dir   = dir;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        c = 1;
        while (!out_valid && c < 64) begin
            @(posedge clk); #1;
            c++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("ready_after_done", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_dir    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_passes", 32'(out_passes), 32'd0);

        // 1: right 0x8000 by 7
        run(16'h8000, 5'd7, 1'b1, cyc);
        chk("t1_latency", 32'(cyc), 32'd4);
        chk("t1_data", 32'(out_data), 32'hFF00);
        chk("t1_sticky", 32'(out_sticky), 32'd0);
        chk("t1_ovf", 32'(out_ovf), 32'd0);
        chk("t1_passes", 32'(out_passes), 32'd3);
        release_out();

        // 2: right with discarded ones
        run(16'h0005, 5'd2, 1'b1, cyc);
        chk("t2a_data", 32'(out_data), 32'h0001);
        chk("t2a_sticky", 32'(out_sticky), 32'd1);
        chk("t2a_passes", 32'(out_passes), 32'd1);
        release_out();
        run(16'h8001, 5'd20, 1'b1, cyc);
        chk("t2b_data", 32'(out_data), 32'hFFFF);
        chk("t2b_sticky", 32'(out_sticky), 32'd1);
        chk("t2b_passes", 32'(out_passes), 32'd7);
        release_out();

        // 3: left shifts around the overflow boundary
        run(16'h0003, 5'd14, 1'b0, cyc);
        chk("t3a_latency", 32'(cyc), 32'd6);
        chk("t3a_data", 32'(out_data), 32'hC000);
        chk("t3a_ovf", 32'(out_ovf), 32'd1);
        chk("t3a_passes", 32'(out_passes), 32'd5);
        chk("t3a_sticky", 32'(out_sticky), 32'd0);
        release_out();
        run(16'h0003, 5'd13, 1'b0, cyc);
        chk("t3b_data", 32'(out_data), 32'h6000);
        chk("t3b_ovf", 32'(out_ovf), 32'd0);
        release_out();

        // 4: zero amount
        run(16'h1234, 5'd0, 1'b0, cyc);
        chk("t4_latency", 32'(cyc), 32'd1);
        chk("t4_data", 32'(out_data), 32'h1234);
        chk("t4_sticky", 32'(out_sticky), 32'd0);
        chk("t4_ovf", 32'(out_ovf), 32'd0);
        chk("t4_passes", 32'(out_passes), 32'd0);
        release_out();

        // 5: backpressure in DONE; a new request must be ignored
        run(16'h0001, 5'd4, 1'b0, cyc);
        chk("t5_data", 32'(out_data), 32'h0010);
        chk("t5_passes", 32'(out_passes), 32'd2);
        hold_data = out_data;
        in_data   = 16'hABCD;
        in_amt    = 5'd1;
        in_dir    = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t5_hold_valid", 32'(out_valid), 32'd1);
            chk("t5_hold_ready", 32'(in_ready), 32'd0);
            chk("t5_hold_data", 32'(out_data), 32'(hold_data));
            chk("t5_hold_passes", 32'(out_passes), 32'd2);
        end
        in_valid = 1'b0;
        release_out();
        chk("t5_idle_data", 32'(out_data), 32'h0010);
        run(16'h4000, 5'd1, 1'b0, cyc);
        chk("t5_next_data", 32'(out_data), 32'h8000);
        chk("t5_next_ovf", 32'(out_ovf), 32'd1);
        chk("t5_next_passes", 32'(out_passes), 32'd1);
        release_out();

        // 6: reset during pass 2 of a 9-position right shift
        in_data  = 16'h7FFF;
        in_amt   = 5'd9;
        in_dir   = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("t6_pass1_passes", 32'(out_passes), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        chk("t6_data", 32'(out_data), 32'h0);
        chk("t6_sticky", 32'(out_sticky), 32'd0);
        chk("t6_ovf", 32'(out_ovf), 32'd0);
        chk("t6_passes", 32'(out_passes), 32'd0);
        run(16'h0010, 5'd3, 1'b1, cyc);
        chk("t6_next_latency", 32'(cyc), 32'd2);
        chk("t6_next_data", 32'(out_data), 32'h0002);
        chk("t6_next_sticky", 32'(out_sticky), 32'd0);
        chk("t6_next_passes", 32'(out_passes), 32'd1);
        release_out();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
